// File: rtl/i2s_pkg.sv
// Shared I2S definitions: receiver state encoding, default word width and
// small sizing helpers used by the receive, transmit and controller blocks.
package i2s_pkg;

    localparam int I2S_DATA_WIDTH = 32;

    typedef enum logic {
        SYNC = 1'b0,
        RECV = 1'b1
    } i2s_state_t;

    // Bit counter must hold 0 .. data_width+1 (saturation value flags long words).
    function automatic int i2s_cnt_width(input int data_width);
        return $clog2(data_width + 2);
    endfunction

endpackage

// File: rtl/i2s_receive_if.sv
// AXI-Stream style word output of the I2S receiver, with the handshake
// signals grouped so producer and consumer share one port.
interface i2s_receive_if
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] M_AXIS_TDATA;
    logic                  M_AXIS_TLAST;
    logic                  M_AXIS_TVALID;
    logic                  M_AXIS_TREADY;

    modport master (
        output M_AXIS_TDATA,
        output M_AXIS_TLAST,
        output M_AXIS_TVALID,
        input  M_AXIS_TREADY
    );

    modport slave (
        input  M_AXIS_TDATA,
        input  M_AXIS_TLAST,
        input  M_AXIS_TVALID,
        output M_AXIS_TREADY
    );

endinterface

// File: rtl/i2s_edge_detect.sv
// Registers the I2S lines once in the mclk domain and flags the cycle in
// which the registered bit clock falls (the sample event).
module i2s_edge_detect (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_sck,
    input  logic i_ws,
    input  logic i_sd,
    output logic o_sck_fall,
    output logic o_ws,
    output logic o_sd
);

    logic r_sck;
    logic r_sck_prev;
    logic r_ws;
    logic r_sd;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sck      <= 1'b0;
            r_sck_prev <= 1'b0;
            r_ws       <= 1'b0;
            r_sd       <= 1'b0;
        end else begin
            r_sck      <= i_sck;
            r_sck_prev <= r_sck;
            r_ws       <= i_ws;
            r_sd       <= i_sd;
        end
    end

    assign o_sck_fall = r_sck_prev & ~r_sck;
    assign o_ws       = r_ws;
    assign o_sd       = r_sd;

endmodule

// File: rtl/i2s_receive.sv
// I2S receiver: deserialises MSB-first channel words, checks word length at
// each word-select transition and presents complete words on a stream port.
module i2s_receive
    import i2s_pkg::*;
#(
    parameter int DATA_WIDTH = I2S_DATA_WIDTH
) (
    input  logic          M_AXIS_ACLK,
    input  logic          M_AXIS_ARESETN,
    input  logic          sck,
    input  logic          ws,
    input  logic          sd,
    i2s_receive_if.master m_axis,
    output logic          overrun,
    output logic          frame_err
);

    localparam int            CW       = i2s_cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(DATA_WIDTH + 1);

    logic w_fall;
    logic w_ws;
    logic w_sd;
    logic w_boundary;
    logic [DATA_WIDTH-1:0] w_word;

    i2s_state_t            r_state;
    logic [DATA_WIDTH-2:0] r_shift;
    logic [CW-1:0]         r_count;
    logic                  r_ws_prev;
    logic [DATA_WIDTH-1:0] r_tdata;
    logic                  r_tlast;
    logic                  r_tvalid;
    logic                  r_overrun;
    logic                  r_frame_err;

    i2s_edge_detect u_edge (
        .i_clk      (M_AXIS_ACLK),
        .i_rst_n    (M_AXIS_ARESETN),
        .i_sck      (sck),
        .i_ws       (ws),
        .i_sd       (sd),
        .o_sck_fall (w_fall),
        .o_ws       (w_ws),
        .o_sd       (w_sd)
    );

    // Only the newest DATA_WIDTH-1 bits are kept; the bit arriving at a
    // boundary completes the word, so the oldest bit is never needed.
    assign w_word     = {r_shift, w_sd};
    assign w_boundary = w_fall & (w_ws != r_ws_prev);

    always_ff @(posedge M_AXIS_ACLK or negedge M_AXIS_ARESETN) begin
        if (!M_AXIS_ARESETN) begin
            r_state     <= SYNC;
            r_shift     <= '0;
            r_count     <= '0;
            r_ws_prev   <= 1'b0;
            r_tdata     <= '0;
            r_tlast     <= 1'b0;
            r_tvalid    <= 1'b0;
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_overrun   <= 1'b0;
            r_frame_err <= 1'b0;

            // A load in the same cycle overrides this clear below.
            if (r_tvalid && m_axis.M_AXIS_TREADY) begin
                r_tvalid <= 1'b0;
            end

            if (w_fall) begin
                r_shift   <= w_word[DATA_WIDTH-2:0];
                r_ws_prev <= w_ws;

                if (w_boundary) begin
                    r_count <= CW'(1);
                    case (r_state)
                        SYNC: begin
                            r_state <= RECV;
                        end
                        RECV: begin
                            if (r_count == CNT_FULL) begin
                                r_tdata   <= w_word;
                                r_tlast   <= ~r_ws_prev;
                                r_tvalid  <= 1'b1;
                                r_overrun <= r_tvalid & ~m_axis.M_AXIS_TREADY;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                        end
                        default: begin
                            r_state <= SYNC;
                        end
                    endcase
                end else if (r_count != CNT_SAT) begin
                    r_count <= r_count + CW'(1);
                end
            end
        end
    end

    assign m_axis.M_AXIS_TDATA  = r_tdata;
    assign m_axis.M_AXIS_TLAST  = r_tlast;
    assign m_axis.M_AXIS_TVALID = r_tvalid;
    assign overrun              = r_overrun;
    assign frame_err            = r_frame_err;

endmodule

// File: tb/tb_i2s_receive.sv
// Directed and randomized checks of i2s_receive against a word-level model:
// words are described by channel, length and data, and the expected stream
// is derived from which words are complete and of full width.
module tb_i2s_receive;
    import i2s_pkg::*;

    localparam int DW = 32;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic sck    = 1'b0;
    logic ws     = 1'b0;
    logic sd     = 1'b0;
    logic tready = 1'b0;
    logic overrun;
    logic frame_err;

    i2s_receive_if #(.DATA_WIDTH(DW)) axis_if ();
    assign axis_if.M_AXIS_TREADY = tready;

    i2s_receive #(.DATA_WIDTH(DW)) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rst_n),
        .sck            (sck),
        .ws             (ws),
        .sd             (sd),
        .m_axis         (axis_if),
        .overrun        (overrun),
        .frame_err      (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [DW:0]  got_q[$];
    logic [DW:0]  exp_q[$];
    int           ovr_cnt  = 0;
    int           ferr_cnt = 0;
    int           exp_ferr = 0;
    int           wl[$];
    logic [63:0]  wd[$];

    // Transfers and pulses are collected mid-cycle, away from the clock edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (axis_if.M_AXIS_TVALID && axis_if.M_AXIS_TREADY) begin
                got_q.push_back({axis_if.M_AXIS_TLAST, axis_if.M_AXIS_TDATA});
                $display("xfer: tdata=0x%08h tlast=%0d", axis_if.M_AXIS_TDATA, axis_if.M_AXIS_TLAST);
            end
            if (overrun)   ovr_cnt++;
            if (frame_err) ferr_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, " tdata"},     64'(axis_if.M_AXIS_TDATA),  64'h0);
        chk({tag, " tlast"},     64'(axis_if.M_AXIS_TLAST),  64'h0);
        chk({tag, " tvalid"},    64'(axis_if.M_AXIS_TVALID), 64'h0);
        chk({tag, " overrun"},   64'(overrun),               64'h0);
        chk({tag, " frame_err"}, 64'(frame_err),             64'h0);
    endtask

    task automatic clear_scoreboard();
        got_q.delete();
        exp_q.delete();
        ovr_cnt  = 0;
        ferr_cnt = 0;
        exp_ferr = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sck   = 1'b0;
        ws    = 1'b0;
        sd    = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        clear_scoreboard();
    endtask

    task automatic add_word(input int len, input logic [63:0] data);
        wl.push_back(len);
        wd.push_back(data);
    endtask

    // Word k has ws = k%2 (starting left). Word 0 only serves to synchronise;
    // every later word closed by a following word is judged: full width gives
    // a transfer tagged left/right, any other length gives one frame error.
    task automatic send_words(input bit trailer, input bit judge);
        bit          dq[$];
        bit          wq[$];
        int          n;
        bit          wsk;
        logic [63:0] tmp;
        n = wl.size();
        for (int k = 0; k < n; k++) begin
            wsk = bit'(k % 2);
            tmp = wd[k];
            for (int i = wl[k] - 1; i >= 0; i--) begin
                dq.push_back(tmp[i]);
                wq.push_back(wsk);
            end
            if (judge && k >= 1 && (trailer || k < n - 1)) begin
                if (wl[k] == DW) exp_q.push_back({~wsk, tmp[DW-1:0]});
                else             exp_ferr++;
            end
        end
        if (trailer) begin
            for (int i = 0; i < 2; i++) begin
                dq.push_back(1'b0);
                wq.push_back(bit'(n % 2));
            end
        end
        // One-bit I2S delay: data lags word select by one bit period.
        for (int p = 0; p < wq.size(); p++) begin
            @(negedge clk);
            sck = 1'b1;
            ws  = wq[p];
            sd  = (p == 0) ? 1'b0 : dq[p-1];
            repeat ($urandom_range(2, 3)) @(negedge clk);
            sck = 1'b0;
            repeat ($urandom_range(2, 3)) @(negedge clk);
        end
        wl.delete();
        wd.delete();
    endtask

    task automatic compare_run(input string tag);
        int n;
        chk({tag, " n_transfers"}, 64'(got_q.size()), 64'(exp_q.size()));
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s xfer%0d tdata", tag, i), 64'(got_q[i][DW-1:0]), 64'(exp_q[i][DW-1:0]));
            chk($sformatf("%s xfer%0d tlast", tag, i), 64'(got_q[i][DW]),     64'(exp_q[i][DW]));
        end
        chk({tag, " frame_err_pulses"}, 64'(ferr_cnt), 64'(exp_ferr));
        chk({tag, " overrun_pulses"},   64'(ovr_cnt),  64'h0);
    endtask

    initial begin
        // Reset state
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_outputs_zero("reset");
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        clear_scoreboard();

        // Left then right words with the consumer always ready
        tready = 1'b1;
        add_word(DW, 64'($urandom));
        add_word(DW, 64'($urandom));
        add_word(DW, 64'hA5A50001);
        add_word(DW, 64'h5A5A0002);
        send_words(1'b1, 1'b1);
        repeat (12) @(negedge clk);
        compare_run("stereo");

        // Consumer stalled across two boundaries: second word overwrites first
        do_reset();
        tready = 1'b0;
        add_word(DW, 64'($urandom));
        add_word(DW, 64'h11111111);
        add_word(DW, 64'h22222222);
        send_words(1'b1, 1'b0);
        repeat (12) @(negedge clk);
        chk("stall overrun_pulses", 64'(ovr_cnt), 64'h1);
        chk("stall no_transfer", 64'(got_q.size()), 64'h0);
        chk("stall tvalid_held", 64'(axis_if.M_AXIS_TVALID), 64'h1);
        @(posedge clk);
        #2;
        tready = 1'b1;
        repeat (8) @(negedge clk);
        chk("stall n_transfers", 64'(got_q.size()), 64'h1);
        if (got_q.size() > 0) begin
            chk("stall tdata", 64'(got_q[0][DW-1:0]), 64'h22222222);
            chk("stall tlast", 64'(got_q[0][DW]), 64'h1);
        end
        chk("stall frame_err_pulses", 64'(ferr_cnt), 64'h0);
        chk("stall tvalid_cleared", 64'(axis_if.M_AXIS_TVALID), 64'h0);

        // Short word between valid words
        do_reset();
        tready = 1'b1;
        add_word(DW, 64'($urandom));
        add_word(DW, 64'($urandom));
        add_word(16, 64'($urandom_range(0, 65535)));
        add_word(DW, 64'hDEADBEEF);
        send_words(1'b1, 1'b1);
        repeat (12) @(negedge clk);
        compare_run("short");
        chk("short frame_err_once", 64'(ferr_cnt), 64'h1);

        // Reset in the middle of a word, with a word pending on the output
        do_reset();
        tready = 1'b0;
        add_word(DW, 64'($urandom));
        add_word(DW, 64'($urandom));
        add_word(10, 64'($urandom_range(0, 1023)));
        send_words(1'b0, 1'b0);
        chk("midreset pending_tvalid", 64'(axis_if.M_AXIS_TVALID), 64'h1);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_outputs_zero("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        clear_scoreboard();
        tready = 1'b1;
        add_word(DW - 10, 64'($urandom_range(0, 4194303)));
        add_word(DW, 64'($urandom));
        send_words(1'b1, 1'b1);
        repeat (12) @(negedge clk);
        compare_run("after_reset");

        // Random lengths and data
        do_reset();
        tready = 1'b1;
        add_word(DW, 64'($urandom));
        for (int k = 0; k < 10; k++) begin
            if ($urandom_range(0, 3) == 0) add_word(int'($urandom_range(8, 40)), {32'($urandom), 32'($urandom)});
            else                           add_word(DW, 64'($urandom));
        end
        send_words(1'b1, 1'b1);
        repeat (12) @(negedge clk);
        compare_run("random");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
